inst_fetch_mod: RTL and testbench
=================================

// Module: inst_fetch_mod
// PURPOSE
//  Opcode/operand capture stage directly upstream of the control unit. Latches bytes from
//  the memory data bus under microcode strobes and resolves the 0xCB prefix into a separate flag.
//  Assembles 8/16-bit immediates and evaluates the conditional-branch flag (flag_adv).
//  Drives inst_buffer/cb_prefix (metadata index) and flag_adv of the control unit.
// PARAMETERS
//  CB_PREFIX     8'hCB  opcode byte treated as the extended-table prefix
//  RESET_OPCODE  8'h00  inst_buffer value after reset (NOP)
// PORTS
//  clock          in   1   system clock, all state on posedge
//  reset          in   1   asynchronous, active-low reset
//  mem_data_in    in   8   memory read data bus
//  fetch_en       in   1   microcode strobe: capture opcode byte this cycle
//  imm_en         in   1   microcode strobe: capture operand byte this cycle
//  flags          in   4   {Z,N,H,C} from flag register
//  halt_bug_arm   in   1   one-cycle pulse: next opcode capture must not advance PC
//  inst_buffer    out  8   current opcode (prefix byte removed)
//  cb_prefix      out  1   1 = inst_buffer indexes the CB half of the metadata table
//  inst_valid     out  1   1 = inst_buffer/cb_prefix hold a complete opcode
//  imm_word       out  16  {imm_hi, imm_lo}
//  flag_adv       out  1   condition selected by inst_buffer[4:3] is true
//  pc_inc         out  1   one-cycle pulse: PC must increment
//  seq_err        out  1   sticky: fetch_en and imm_en asserted together
// BEHAVIOUR
//  - Reset (reset==0, async): state=S_OPCODE, inst_buffer=RESET_OPCODE, cb_prefix=0,
//    inst_valid=1, imm_word=0, imm_cnt=0, flag_adv=0, pc_inc=0, seq_err=0, halt_bug=0.
//  - States: S_OPCODE (awaiting first byte), S_CB (prefix seen, awaiting second), S_EXEC.
//  - All captures register on the posedge where the strobe is high; outputs valid next cycle.
//  - S_OPCODE/S_EXEC + fetch_en: byte==CB_PREFIX -> S_CB, inst_valid=0, inst_buffer held;
//    else inst_buffer=byte, cb_prefix=0, inst_valid=1 -> S_EXEC. imm_cnt cleared either way.
//  - S_CB + fetch_en: inst_buffer=byte (0xCB included, no re-prefix), cb_prefix=1,
//    inst_valid=1 -> S_EXEC.
//  - imm_en (S_EXEC only): imm_cnt==0 -> imm_word[7:0]=byte; imm_cnt==1 -> imm_word[15:8]=byte;
//    imm_cnt toggles 0->1->0 (third byte overwrites low). imm_en in S_OPCODE/S_CB ignored.
//  - fetch_en && imm_en same cycle: fetch_en wins, imm_en dropped, seq_err<=1 (cleared by reset only).
//  - pc_inc: high exactly one cycle after each accepted capture (fetch or imm), else 0.
//  - flag_adv: registered each cycle from current inst_buffer[4:3]: 00 !Z, 01 Z, 10 !C, 11 C;
//    forced 0 when inst_valid==0. One-cycle latency from flags change.
//  - Back-to-back strobes every cycle are legal; each produces its own pc_inc pulse.
//  - Reset mid-prefix (S_CB) returns to S_OPCODE with cb_prefix=0; no pc_inc emitted.
// CONFIGURATION
//  INST_FETCH_HALT_BUG_EN defined: halt_bug_arm sets internal halt_bug; the next fetch_en
//    capture produces no pc_inc pulse and clears halt_bug (byte fetched twice, DMG HALT bug).
//    Prefix byte capture consumes halt_bug the same way.
//  Not defined: halt_bug_arm ignored; halt_bug logic absent; every capture pulses pc_inc.
// TESTING
//  1. Reset released, fetch_en with 8'h3E -> next cycle inst_buffer=3E, cb_prefix=0, pc_inc=1 one cycle.
//  2. fetch_en 8'hCB then fetch_en 8'h7C -> after first inst_valid=0; after second
//     inst_buffer=7C, cb_prefix=1, inst_valid=1; two pc_inc pulses.
//  3. opcode 8'hC3, imm_en 8'h34 then 8'h12 -> imm_word=16'h1234; third imm_en 8'hAA -> 16'h12AA.
//  4. opcode 8'h28 (JR Z), flags=4'b1000 -> flag_adv=1 next cycle; flags=0 -> flag_adv=0.
//  5. fetch_en and imm_en both high with 8'h55 -> inst_buffer=55, imm_word unchanged, seq_err=1.
//  6. HALT_BUG_EN: halt_bug_arm pulse, fetch_en 8'h04 -> inst_buffer=04, pc_inc stays 0;
//     following fetch pulses pc_inc. Without macro -> pc_inc=1.

Source files
------------

// File: rtl/inst_fetch_mod_if.sv
// Bundle between the microcode sequencer/memory bus and the fetch stage.
// The master drives strobes and data; the slave (fetch stage) returns the decoded opcode state.
interface inst_fetch_mod_if;
    logic [7:0]  mem_data_in;
    logic        fetch_en;
    logic        imm_en;
    logic [3:0]  flags;
    logic        halt_bug_arm;
    logic [7:0]  inst_buffer;
    logic        cb_prefix;
    logic        inst_valid;
    logic [15:0] imm_word;
    logic        flag_adv;
    logic        pc_inc;
    logic        seq_err;

    modport master (
        output mem_data_in, fetch_en, imm_en, flags, halt_bug_arm,
        input  inst_buffer, cb_prefix, inst_valid, imm_word, flag_adv, pc_inc, seq_err
    );

    modport slave (
        input  mem_data_in, fetch_en, imm_en, flags, halt_bug_arm,
        output inst_buffer, cb_prefix, inst_valid, imm_word, flag_adv, pc_inc, seq_err
    );
endinterface

// File: rtl/inst_fetch_mod.sv
// Opcode/immediate capture stage with 0xCB prefix folding and branch-condition evaluation.
// Latency: captures visible one cycle after the strobe edge; flag_adv one cycle after flags/opcode.
// No backpressure: strobes are accepted every cycle. INST_FETCH_HALT_BUG_EN adds the HALT-bug skip.
module inst_fetch_mod #(
    parameter logic [7:0] CB_PREFIX    = 8'hCB,
    parameter logic [7:0] RESET_OPCODE = 8'h00
) (
    input  logic             clock,
    input  logic             reset,
    inst_fetch_mod_if.slave  bus
);

    typedef enum logic [1:0] {S_OPCODE, S_CB, S_EXEC} state_t;

    state_t      state_q, state_d;
    logic [7:0]  ib_q, ib_d;
    logic        cb_q, cb_d;
    logic        valid_q, valid_d;
    logic [15:0] imm_q, imm_d;
    logic        imm_cnt_q, imm_cnt_d;
    logic        flag_adv_q, flag_adv_d;
    logic        pc_inc_q, pc_inc_d;
    logic        seq_err_q, seq_err_d;
    logic        halt_bug_q, halt_bug_d;
    logic        cond;

    // Only Z (bit 3) and C (bit 0) feed branch conditions.
    logic [1:0] unused_nh;
    assign unused_nh = bus.flags[2:1];

    always_comb begin
        unique case (ib_q[4:3])
            2'b00:   cond = ~bus.flags[3];
            2'b01:   cond =  bus.flags[3];
            2'b10:   cond = ~bus.flags[0];
            default: cond =  bus.flags[0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ib_d       = ib_q;
        cb_d       = cb_q;
        valid_d    = valid_q;
        imm_d      = imm_q;
        imm_cnt_d  = imm_cnt_q;
        seq_err_d  = seq_err_q;
        halt_bug_d = halt_bug_q;
        pc_inc_d   = 1'b0;
        flag_adv_d = valid_q & cond;

        if (bus.fetch_en) begin
            imm_cnt_d  = 1'b0;
            pc_inc_d   = ~halt_bug_q;
            halt_bug_d = 1'b0;
            if (state_q == S_CB) begin
                // Second byte after the prefix is taken verbatim, even another 0xCB.
                ib_d    = bus.mem_data_in;
                cb_d    = 1'b1;
                valid_d = 1'b1;
                state_d = S_EXEC;
            end else if (bus.mem_data_in == CB_PREFIX) begin
                valid_d = 1'b0;
                state_d = S_CB;
            end else begin
                ib_d    = bus.mem_data_in;
                cb_d    = 1'b0;
                valid_d = 1'b1;
                state_d = S_EXEC;
            end
            if (bus.imm_en) begin
                seq_err_d = 1'b1;
            end
        end else if (bus.imm_en && state_q == S_EXEC) begin
            if (imm_cnt_q) begin
                imm_d[15:8] = bus.mem_data_in;
            end else begin
                imm_d[7:0]  = bus.mem_data_in;
            end
            imm_cnt_d = ~imm_cnt_q;
            pc_inc_d  = 1'b1;
        end

`ifdef INST_FETCH_HALT_BUG_EN
        if (bus.halt_bug_arm) begin
            halt_bug_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_OPCODE;
            ib_q       <= RESET_OPCODE;
            cb_q       <= 1'b0;
            valid_q    <= 1'b1;
            imm_q      <= 16'h0000;
            imm_cnt_q  <= 1'b0;
            flag_adv_q <= 1'b0;
            pc_inc_q   <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ib_q       <= ib_d;
            cb_q       <= cb_d;
            valid_q    <= valid_d;
            imm_q      <= imm_d;
            imm_cnt_q  <= imm_cnt_d;
            flag_adv_q <= flag_adv_d;
            pc_inc_q   <= pc_inc_d;
            seq_err_q  <= seq_err_d;
        end
    end

`ifdef INST_FETCH_HALT_BUG_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halt_bug_q <= 1'b0;
        end else begin
            halt_bug_q <= halt_bug_d;
        end
    end
`else
    logic unused_halt;
    assign unused_halt = bus.halt_bug_arm ^ halt_bug_d;
    assign halt_bug_q  = 1'b0;
`endif

    assign bus.inst_buffer = ib_q;
    assign bus.cb_prefix   = cb_q;
    assign bus.inst_valid  = valid_q;
    assign bus.imm_word    = imm_q;
    assign bus.flag_adv    = flag_adv_q;
    assign bus.pc_inc      = pc_inc_q;
    assign bus.seq_err     = seq_err_q;

endmodule

// File: tb/tb_inst_fetch_mod.sv
// Directed stimulus with a cycle-tagged expectation queue; a negedge monitor pops and compares.
module tb_inst_fetch_mod;

`ifdef INST_FETCH_HALT_BUG_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   passes = 0;
    int   nid    = 0;

    inst_fetch_mod_if bus();

    inst_fetch_mod dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    typedef struct {
        int          cyc;
        int          id;
        logic [7:0]  ib;
        logic        cb;
        logic        iv;
        logic [15:0] imm;
        logic        pc;
        logic        se;
        logic        chk_fa;
        logic        fa;
    } exp_t;

    exp_t q[$];
    exp_t e;
    bit   seen;

    task automatic expect_at(input int off, input logic [7:0] ib, input logic cb, input logic iv,
                             input logic [15:0] imm, input logic pc, input logic se,
                             input logic chk_fa, input logic fa);
        exp_t r;
        r.cyc = cyc + off; r.id = nid; r.ib = ib; r.cb = cb; r.iv = iv; r.imm = imm;
        r.pc = pc; r.se = se; r.chk_fa = chk_fa; r.fa = fa;
        nid++;
        q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        bus.fetch_en     = 1'b0;
        bus.imm_en       = 1'b0;
        bus.halt_bug_arm = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] d);
        bus.mem_data_in = d;
        bus.fetch_en    = 1'b1;
    endtask

    task automatic imm(input logic [7:0] d);
        bus.mem_data_in = d;
        bus.imm_en      = 1'b1;
    endtask

    always @(negedge clock) begin
        seen = 1'b0;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                $display("FAIL chk%0d: expectation for cycle %0d not sampled (now %0d)", e.id, e.cyc, cyc);
            end else begin
                seen = 1'b1;
                if ({bus.inst_buffer, bus.cb_prefix, bus.inst_valid, bus.imm_word, bus.pc_inc, bus.seq_err}
                        !== {e.ib, e.cb, e.iv, e.imm, e.pc, e.se}
                    || (e.chk_fa && bus.flag_adv !== e.fa)) begin
                    $display("FAIL chk%0d cyc %0d: got ib=%h cb=%b iv=%b imm=%h pc=%b se=%b fa=%b, want ib=%h cb=%b iv=%b imm=%h pc=%b se=%b fa=%b(chk=%b)",
                             e.id, cyc, bus.inst_buffer, bus.cb_prefix, bus.inst_valid, bus.imm_word,
                             bus.pc_inc, bus.seq_err, bus.flag_adv,
                             e.ib, e.cb, e.iv, e.imm, e.pc, e.se, e.fa, e.chk_fa);
                end else begin
                    passes++;
                end
            end
        end
        if (!seen && bus.pc_inc !== 1'b0) begin
            checks++;
            $display("FAIL stray_pc_inc cyc %0d: got pc_inc=%b, want 0", cyc, bus.pc_inc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_data_in  = 8'h00;
        bus.fetch_en     = 1'b0;
        bus.imm_en       = 1'b0;
        bus.flags        = 4'b0000;
        bus.halt_bug_arm = 1'b0;

        // Reset values while reset is held
        expect_at(1, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        tick();

        // Plain opcode, single pc_inc pulse
        fetch(8'h3E); expect_at(1, 8'h3E, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        expect_at(1, 8'h3E, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); tick();

        // CB prefix then second byte
        fetch(8'hCB); expect_at(1, 8'h3E, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        fetch(8'h7C); expect_at(1, 8'h7C, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0); tick();

        // Immediate assembly, back-to-back strobes
        fetch(8'hC3); expect_at(1, 8'hC3, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        imm(8'h34);   expect_at(1, 8'hC3, 1'b0, 1'b1, 16'h0034, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        imm(8'h12);   expect_at(1, 8'hC3, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        imm(8'hAA);   expect_at(1, 8'hC3, 1'b0, 1'b1, 16'h12AA, 1'b1, 1'b0, 1'b0, 1'b0); tick();

        // imm_en ignored in S_CB; fetch clears imm_cnt
        fetch(8'hCB); expect_at(1, 8'hC3, 1'b0, 1'b0, 16'h12AA, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        imm(8'h99);   expect_at(1, 8'hC3, 1'b0, 1'b0, 16'h12AA, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        fetch(8'h11); expect_at(1, 8'h11, 1'b1, 1'b1, 16'h12AA, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        imm(8'h56);   expect_at(1, 8'h11, 1'b1, 1'b1, 16'h1256, 1'b1, 1'b0, 1'b0, 1'b0); tick();

        // flag_adv: JR Z (bits 01 -> Z)
        bus.flags = 4'b1000;
        fetch(8'h28);
        expect_at(1, 8'h28, 1'b0, 1'b1, 16'h1256, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(2, 8'h28, 1'b0, 1'b1, 16'h1256, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); tick();
        bus.flags = 4'b0000;
        expect_at(1, 8'h28, 1'b0, 1'b1, 16'h1256, 1'b0, 1'b0, 1'b1, 1'b0); tick();

        // flag_adv forced low while mid-prefix, then C condition on a CB opcode
        bus.flags = 4'b1000;
        fetch(8'hCB);
        expect_at(1, 8'h28, 1'b0, 1'b0, 16'h1256, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(2, 8'h28, 1'b0, 1'b0, 16'h1256, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        bus.flags = 4'b0001;
        fetch(8'h38);
        expect_at(1, 8'h38, 1'b1, 1'b1, 16'h1256, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(2, 8'h38, 1'b1, 1'b1, 16'h1256, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); tick();

        // Simultaneous strobes: fetch wins, seq_err sticks
        fetch(8'h55); bus.imm_en = 1'b1;
        expect_at(1, 8'h55, 1'b0, 1'b1, 16'h1256, 1'b1, 1'b1, 1'b0, 1'b0); tick();
        expect_at(1, 8'h55, 1'b0, 1'b1, 16'h1256, 1'b0, 1'b1, 1'b0, 1'b0); tick();

        // HALT bug: armed fetch suppresses pc_inc only when the feature is built in
        bus.halt_bug_arm = 1'b1; tick();
        fetch(8'h04); expect_at(1, 8'h04, 1'b0, 1'b1, 16'h1256, HB ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0); tick();
        fetch(8'h05); expect_at(1, 8'h05, 1'b0, 1'b1, 16'h1256, 1'b1, 1'b1, 1'b0, 1'b0); tick();
        bus.halt_bug_arm = 1'b1; tick();
        fetch(8'hCB); expect_at(1, 8'h05, 1'b0, 1'b0, 16'h1256, HB ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0); tick();
        fetch(8'h06); expect_at(1, 8'h06, 1'b1, 1'b1, 16'h1256, 1'b1, 1'b1, 1'b0, 1'b0); tick();

        // Reset while awaiting the prefix's second byte kills the pending pc_inc
        fetch(8'hCB); tick();
        reset = 1'b0;
        expect_at(0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        fetch(8'h7C); expect_at(1, 8'h7C, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        tick(); tick();

        checks++;
        if (q.size() != 0) begin
            $display("FAIL queue_drain: got %0d pending expectations, want 0", q.size());
        end else begin
            passes++;
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
